// File: rtl/sat_bin_pkg.sv
// rtl/sat_bin_pkg.sv - sat_bin_loader sizing constants, FSM states and helpers
package sat_bin_pkg;

  localparam int NUM_CLAUSES      = 8;
  localparam int NUM_VARS         = 8;
  localparam int NUM_LVLS         = 8;
  localparam int WIDTH_BIN_ID     = 10;
  localparam int WIDTH_LVL        = 16;
  localparam int WIDTH_VAR_STATES = 19;
  localparam int WIDTH_LVL_STATES = 11;

  // Row counters need at least one bit even for a single-row bin.
  function automatic int row_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CL_AW    = row_aw(NUM_CLAUSES);
  localparam int CLAUSE_W = NUM_VARS * 2;
  localparam int VS_W     = WIDTH_VAR_STATES * NUM_VARS;
  localparam int LS_W     = WIDTH_LVL_STATES * NUM_LVLS;
  localparam int CMEM_AW  = WIDTH_BIN_ID + CL_AW;

  typedef enum logic [2:0] {
    IDLE,
    LD_C,
    LD_S,
    START,
    RUN,
    WB_C,
    WB_S,
    DONE
  } state_e;

endpackage

// File: rtl/bin_row_seq.sv
// rtl/bin_row_seq.sv - clause row counter with one-hot row decode
module bin_row_seq #(
  parameter int NUM_ROWS = 8,
  parameter int AW       = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                adv_i,
  output logic [AW-1:0]       row_o,
  output logic [NUM_ROWS-1:0] onehot_o,
  output logic                last_o,
  output logic                busy_o
);

  logic [AW-1:0] row_q, row_d;
  logic          busy_q, busy_d;

  // Next row: start restarts at row 0, advancing stops exactly at the last row.
  always_comb begin
    row_d  = row_q;
    busy_d = busy_q;
    if (start_i) begin
      row_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q && adv_i) begin
      if (last_o) begin
        busy_d = 1'b0;
      end else begin
        row_d = row_q + AW'(1);
      end
    end
  end

  // Counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      row_q  <= row_d;
      busy_q <= busy_d;
    end
  end

  // One-hot strobe for the current row.
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      onehot_o[i] = (row_q == AW'(i));
    end
  end

  assign row_o  = row_q;
  assign last_o = (row_q == AW'(NUM_ROWS - 1));
  assign busy_o = busy_q;

endmodule

// File: rtl/sat_bin_loader.sv
// rtl/sat_bin_loader.sv - swaps one bin into sat_engine and back; SAT_BIN_LOADER_CYCLE_CNT_EN adds run_cycles_o
module sat_bin_loader
  import sat_bin_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [WIDTH_BIN_ID-1:0] bin_id_i,
  input  logic [WIDTH_LVL-1:0]    load_lvl_i,
  input  logic [WIDTH_LVL-1:0]    base_lvl_i,
  output logic                    done_o,
  output logic                    sat_o,
  output logic                    unsat_o,
  output logic [WIDTH_LVL-1:0]    cur_lvl_o,
  output logic [WIDTH_LVL-1:0]    bkt_lvl_o,
  output logic [WIDTH_BIN_ID-1:0] bkt_bin_o,
  output logic                    cmem_rd_o,
  output logic                    cmem_wr_o,
  output logic [CMEM_AW-1:0]      cmem_addr_o,
  output logic [CLAUSE_W-1:0]     cmem_wdata_o,
  input  logic [CLAUSE_W-1:0]     cmem_rdata_i,
  output logic                    smem_rd_o,
  output logic                    smem_wr_o,
  output logic [WIDTH_BIN_ID-1:0] smem_addr_o,
  output logic [VS_W-1:0]         smem_vs_wdata_o,
  input  logic [VS_W-1:0]         smem_vs_rdata_i,
  output logic [LS_W-1:0]         smem_ls_wdata_o,
  input  logic [LS_W-1:0]         smem_ls_rdata_i,
  output logic                    start_core_o,
  output logic [WIDTH_LVL-1:0]    cur_bin_num_o,
  output logic [WIDTH_LVL-1:0]    load_lvl_o,
  input  logic                    done_core_i,
  input  logic                    sat_i,
  input  logic                    unsat_i,
  input  logic [WIDTH_LVL-1:0]    cur_lvl_i,
  input  logic [WIDTH_LVL-1:0]    bkt_lvl_i,
  input  logic [WIDTH_BIN_ID-1:0] bkt_bin_i,
  output logic [NUM_CLAUSES-1:0]  wr_carray_o,
  output logic [NUM_CLAUSES-1:0]  rd_carray_o,
  output logic [CLAUSE_W-1:0]     clause_o,
  input  logic [CLAUSE_W-1:0]     clause_i,
  output logic [NUM_VARS-1:0]     wr_var_states_o,
  output logic [VS_W-1:0]         vars_states_o,
  input  logic [VS_W-1:0]         vars_states_i,
  output logic [NUM_LVLS-1:0]     wr_lvl_states_o,
  output logic [LS_W-1:0]         lvl_states_o,
  input  logic [LS_W-1:0]         lvl_states_i,
  output logic                    base_lvl_en_o,
  output logic [WIDTH_LVL-1:0]    base_lvl_o
`ifdef SAT_BIN_LOADER_CYCLE_CNT_EN
  ,
  output logic [31:0]             run_cycles_o
`endif
);

  state_e                  state_q;
  logic [WIDTH_BIN_ID-1:0] bin_q;
  logic [WIDTH_LVL-1:0]    load_lvl_q;
  logic [WIDTH_LVL-1:0]    base_lvl_q;
  logic                    cmem_rd_q;
  logic                    cmem_wr_q;
  logic [NUM_CLAUSES-1:0]  wr_carray_q;
  logic                    smem_rd_q;
  logic                    smem_wr_q;
  logic                    wr_st_q;
  logic                    base_en_q;
  logic                    start_core_q;
  logic                    done_q;
  logic                    ph_q;
  logic                    sat_q;
  logic                    unsat_q;
  logic [WIDTH_LVL-1:0]    cur_lvl_q;
  logic [WIDTH_LVL-1:0]    bkt_lvl_q;
  logic [WIDTH_BIN_ID-1:0] bkt_bin_q;

  logic                    seq_start;
  logic                    seq_adv;
  logic [CL_AW-1:0]        seq_row;
  logic [NUM_CLAUSES-1:0]  seq_onehot;
  logic                    seq_last;
  logic                    seq_busy;

  // One counter walks the rows for both the load and the write-back pass.
  assign seq_start = ((state_q == IDLE) && start_i) || ((state_q == RUN) && done_core_i);
  assign seq_adv   = ((state_q == LD_C) && cmem_rd_q) || (state_q == WB_C);

  bin_row_seq #(
    .NUM_ROWS (NUM_CLAUSES),
    .AW       (CL_AW)
  ) u_row_seq (
    .clk      (clk),
    .rst      (rst),
    .start_i  (seq_start),
    .adv_i    (seq_adv),
    .row_o    (seq_row),
    .onehot_o (seq_onehot),
    .last_o   (seq_last),
    .busy_o   (seq_busy)
  );

  // Bin swap sequencer; every strobe is a register set one cycle ahead of use.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bin_q        <= '0;
      load_lvl_q   <= '0;
      base_lvl_q   <= '0;
      cmem_rd_q    <= 1'b0;
      cmem_wr_q    <= 1'b0;
      wr_carray_q  <= '0;
      smem_rd_q    <= 1'b0;
      smem_wr_q    <= 1'b0;
      wr_st_q      <= 1'b0;
      base_en_q    <= 1'b0;
      start_core_q <= 1'b0;
      done_q       <= 1'b0;
      ph_q         <= 1'b0;
      sat_q        <= 1'b0;
      unsat_q      <= 1'b0;
      cur_lvl_q    <= '0;
      bkt_lvl_q    <= '0;
      bkt_bin_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            bin_q      <= bin_id_i;
            load_lvl_q <= load_lvl_i;
            base_lvl_q <= base_lvl_i;
            sat_q      <= 1'b0;
            unsat_q    <= 1'b0;
            cur_lvl_q  <= '0;
            bkt_lvl_q  <= '0;
            bkt_bin_q  <= '0;
            cmem_rd_q  <= 1'b1;
            state_q    <= LD_C;
          end
        end
        LD_C: begin
          // The engine row write trails the memory read by the read latency.
          wr_carray_q <= cmem_rd_q ? seq_onehot : '0;
          if (cmem_rd_q && seq_busy && seq_last) begin
            cmem_rd_q <= 1'b0;
          end
          if (!cmem_rd_q) begin
            smem_rd_q <= 1'b1;
            ph_q      <= 1'b0;
            state_q   <= LD_S;
          end
        end
        LD_S: begin
          if (!ph_q) begin
            smem_rd_q <= 1'b0;
            wr_st_q   <= 1'b1;
            base_en_q <= 1'b1;
            ph_q      <= 1'b1;
          end else begin
            wr_st_q      <= 1'b0;
            base_en_q    <= 1'b0;
            start_core_q <= 1'b1;
            state_q      <= START;
          end
        end
        START: begin
          start_core_q <= 1'b0;
          state_q      <= RUN;
        end
        RUN: begin
          if (done_core_i) begin
            sat_q     <= sat_i;
            unsat_q   <= unsat_i;
            cur_lvl_q <= cur_lvl_i;
            bkt_lvl_q <= bkt_lvl_i;
            bkt_bin_q <= bkt_bin_i;
            cmem_wr_q <= 1'b1;
            state_q   <= WB_C;
          end
        end
        WB_C: begin
          if (seq_busy && seq_last) begin
            cmem_wr_q <= 1'b0;
            smem_wr_q <= 1'b1;
            state_q   <= WB_S;
          end
        end
        WB_S: begin
          smem_wr_q <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef SAT_BIN_LOADER_CYCLE_CNT_EN
  logic [31:0] run_cnt_q;

  // Engine busy time for the current bin, saturating rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_q <= '0;
    end else if (state_q == START) begin
      run_cnt_q <= '0;
    end else if ((state_q == RUN) && (run_cnt_q != 32'hFFFF_FFFF)) begin
      run_cnt_q <= run_cnt_q + 32'd1;
    end
  end

  assign run_cycles_o = run_cnt_q;
`else
  // No engine cycle counter in this build.
`endif

  assign done_o          = done_q;
  assign sat_o           = sat_q;
  assign unsat_o         = unsat_q;
  assign cur_lvl_o       = cur_lvl_q;
  assign bkt_lvl_o       = bkt_lvl_q;
  assign bkt_bin_o       = bkt_bin_q;
  assign cmem_rd_o       = cmem_rd_q;
  assign cmem_wr_o       = cmem_wr_q;
  assign cmem_addr_o     = {bin_q, seq_row};
  assign cmem_wdata_o    = clause_i;
  assign smem_rd_o       = smem_rd_q;
  assign smem_wr_o       = smem_wr_q;
  assign smem_addr_o     = bin_q;
  assign smem_vs_wdata_o = vars_states_i;
  assign smem_ls_wdata_o = lvl_states_i;
  assign start_core_o    = start_core_q;
  assign cur_bin_num_o   = WIDTH_LVL'(bin_q);
  assign load_lvl_o      = load_lvl_q;
  assign wr_carray_o     = wr_carray_q;
  assign rd_carray_o     = cmem_wr_q ? seq_onehot : '0;
  assign clause_o        = cmem_rdata_i;
  assign wr_var_states_o = {NUM_VARS{wr_st_q}};
  assign vars_states_o   = smem_vs_rdata_i;
  assign wr_lvl_states_o = {NUM_LVLS{wr_st_q}};
  assign lvl_states_o    = smem_ls_rdata_i;
  assign base_lvl_en_o   = base_en_q;
  assign base_lvl_o      = base_lvl_q;

endmodule

// File: tb/tb_sat_bin_loader.sv
// tb/tb_sat_bin_loader.sv - directed bench for sat_bin_loader with memory and engine models
module tb_sat_bin_loader;
  import sat_bin_pkg::*;

  localparam int N = NUM_CLAUSES;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start_i;
  logic [WIDTH_BIN_ID-1:0] bin_id_i;
  logic [WIDTH_LVL-1:0]    load_lvl_i, base_lvl_i;
  logic                    done_o, sat_o, unsat_o;
  logic [WIDTH_LVL-1:0]    cur_lvl_o, bkt_lvl_o;
  logic [WIDTH_BIN_ID-1:0] bkt_bin_o;
  logic                    cmem_rd_o, cmem_wr_o;
  logic [CMEM_AW-1:0]      cmem_addr_o;
  logic [CLAUSE_W-1:0]     cmem_wdata_o, cmem_rdata_i;
  logic                    smem_rd_o, smem_wr_o;
  logic [WIDTH_BIN_ID-1:0] smem_addr_o;
  logic [VS_W-1:0]         smem_vs_wdata_o, smem_vs_rdata_i;
  logic [LS_W-1:0]         smem_ls_wdata_o, smem_ls_rdata_i;
  logic                    start_core_o;
  logic [WIDTH_LVL-1:0]    cur_bin_num_o, load_lvl_o;
  logic                    done_core_i, sat_i, unsat_i;
  logic [WIDTH_LVL-1:0]    cur_lvl_i, bkt_lvl_i;
  logic [WIDTH_BIN_ID-1:0] bkt_bin_i;
  logic [N-1:0]            wr_carray_o, rd_carray_o;
  logic [CLAUSE_W-1:0]     clause_o, clause_i;
  logic [NUM_VARS-1:0]     wr_var_states_o;
  logic [VS_W-1:0]         vars_states_o, vars_states_i;
  logic [NUM_LVLS-1:0]     wr_lvl_states_o;
  logic [LS_W-1:0]         lvl_states_o, lvl_states_i;
  logic                    base_lvl_en_o;
  logic [WIDTH_LVL-1:0]    base_lvl_o;
`ifdef SAT_BIN_LOADER_CYCLE_CNT_EN
  logic [31:0]             run_cycles_o;
`endif

  sat_bin_loader dut (
    .clk(clk), .rst(rst), .start_i(start_i), .bin_id_i(bin_id_i),
    .load_lvl_i(load_lvl_i), .base_lvl_i(base_lvl_i),
    .done_o(done_o), .sat_o(sat_o), .unsat_o(unsat_o),
    .cur_lvl_o(cur_lvl_o), .bkt_lvl_o(bkt_lvl_o), .bkt_bin_o(bkt_bin_o),
    .cmem_rd_o(cmem_rd_o), .cmem_wr_o(cmem_wr_o), .cmem_addr_o(cmem_addr_o),
    .cmem_wdata_o(cmem_wdata_o), .cmem_rdata_i(cmem_rdata_i),
    .smem_rd_o(smem_rd_o), .smem_wr_o(smem_wr_o), .smem_addr_o(smem_addr_o),
    .smem_vs_wdata_o(smem_vs_wdata_o), .smem_vs_rdata_i(smem_vs_rdata_i),
    .smem_ls_wdata_o(smem_ls_wdata_o), .smem_ls_rdata_i(smem_ls_rdata_i),
    .start_core_o(start_core_o), .cur_bin_num_o(cur_bin_num_o), .load_lvl_o(load_lvl_o),
    .done_core_i(done_core_i), .sat_i(sat_i), .unsat_i(unsat_i),
    .cur_lvl_i(cur_lvl_i), .bkt_lvl_i(bkt_lvl_i), .bkt_bin_i(bkt_bin_i),
    .wr_carray_o(wr_carray_o), .rd_carray_o(rd_carray_o),
    .clause_o(clause_o), .clause_i(clause_i),
    .wr_var_states_o(wr_var_states_o), .vars_states_o(vars_states_o), .vars_states_i(vars_states_i),
    .wr_lvl_states_o(wr_lvl_states_o), .lvl_states_o(lvl_states_o), .lvl_states_i(lvl_states_i),
    .base_lvl_en_o(base_lvl_en_o), .base_lvl_o(base_lvl_o)
`ifdef SAT_BIN_LOADER_CYCLE_CNT_EN
    , .run_cycles_o(run_cycles_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bin memories with one-cycle read latency plus a bench preload port.
  logic [CLAUSE_W-1:0] cmem [1 << CMEM_AW];
  logic [VS_W-1:0]     svs  [1 << WIDTH_BIN_ID];
  logic [LS_W-1:0]     sls  [1 << WIDTH_BIN_ID];
  logic                pl_c_en = 1'b0, pl_s_en = 1'b0;
  logic [CMEM_AW-1:0]  pl_c_addr;
  logic [CLAUSE_W-1:0] pl_c_data;
  logic [WIDTH_BIN_ID-1:0] pl_s_addr;
  logic [VS_W-1:0]     pl_vs;
  logic [LS_W-1:0]     pl_ls;

  always @(posedge clk) begin
    if (pl_c_en) cmem[pl_c_addr] <= pl_c_data;
    else if (cmem_wr_o) cmem[cmem_addr_o] <= cmem_wdata_o;
    if (cmem_rd_o) cmem_rdata_i <= cmem[cmem_addr_o];
    if (pl_s_en) begin
      svs[pl_s_addr] <= pl_vs;
      sls[pl_s_addr] <= pl_ls;
    end else if (smem_wr_o) begin
      svs[smem_addr_o] <= smem_vs_wdata_o;
      sls[smem_addr_o] <= smem_ls_wdata_o;
    end
    if (smem_rd_o) begin
      smem_vs_rdata_i <= svs[smem_addr_o];
      smem_ls_rdata_i <= sls[smem_addr_o];
    end
  end

  // Engine storage model with a bench override used to mimic solver updates.
  logic [CLAUSE_W-1:0] eng_c [N];
  logic [VS_W-1:0]     eng_vs;
  logic [LS_W-1:0]     eng_ls;
  logic                mod_en = 1'b0;
  logic [CL_AW-1:0]    mod_row;
  logic [CLAUSE_W-1:0] mod_val;
  logic [VS_W-1:0]     mod_vs;
  logic [LS_W-1:0]     mod_ls;

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) if (wr_carray_o[k]) eng_c[k] <= clause_o;
    if (&wr_var_states_o) eng_vs <= vars_states_o;
    if (&wr_lvl_states_o) eng_ls <= lvl_states_o;
    if (mod_en) begin
      eng_c[mod_row] <= mod_val;
      eng_vs <= mod_vs;
      eng_ls <= mod_ls;
    end
  end

  always_comb begin
    clause_i = '0;
    for (int k = 0; k < N; k++) if (rd_carray_o[k]) clause_i = eng_c[k];
  end
  assign vars_states_i = eng_vs;
  assign lvl_states_i  = eng_ls;

  // Cumulative observation log, sampled on the falling edge.
  logic [CMEM_AW-1:0]  rd_addr_log [$];
  logic [N-1:0]        wr_oh_log [$];
  logic [CLAUSE_W-1:0] wr_cl_log [$];
  int                  wr_cyc_log [$];
  int                  n_start = 0, n_done = 0;

  always @(negedge clk) begin
    if (cmem_rd_o) rd_addr_log.push_back(cmem_addr_o);
    if (wr_carray_o != '0) begin
      wr_oh_log.push_back(wr_carray_o);
      wr_cl_log.push_back(clause_o);
      wr_cyc_log.push_back(cyc);
    end
    if (start_core_o) n_start++;
    if (done_o) n_done++;
  end

  int n_checks = 0, n_errors = 0;
  int t_issue, t_core, t_dcore, t_done;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic preload_c(input logic [WIDTH_BIN_ID-1:0] b, input int row, input logic [CLAUSE_W-1:0] v);
    @(negedge clk);
    pl_c_en = 1'b1; pl_c_addr = {b, CL_AW'(row)}; pl_c_data = v;
    @(negedge clk);
    pl_c_en = 1'b0;
  endtask

  task automatic preload_s(input logic [WIDTH_BIN_ID-1:0] b, input logic [VS_W-1:0] vs, input logic [LS_W-1:0] ls);
    @(negedge clk);
    pl_s_en = 1'b1; pl_s_addr = b; pl_vs = vs; pl_ls = ls;
    @(negedge clk);
    pl_s_en = 1'b0;
  endtask

  task automatic issue_start(input logic [WIDTH_BIN_ID-1:0] b, input logic [WIDTH_LVL-1:0] ll,
                             input logic [WIDTH_LVL-1:0] bl, input bit hold);
    @(negedge clk);
    start_i = 1'b1; bin_id_i = b; load_lvl_i = ll; base_lvl_i = bl; t_issue = cyc;
    if (!hold) begin
      @(negedge clk);
      start_i = 1'b0;
      bin_id_i = 10'h3FF;
    end
  endtask

  task automatic wait_core();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (start_core_o) begin seen = 1'b1; t_core = cyc; end
    end
    check("start_core_seen", 256'(seen), 256'd1);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done_o) begin seen = 1'b1; t_done = cyc; end
    end
    check("done_seen", 256'(seen), 256'd1);
  endtask

  task automatic eng_modify(input int row, input logic [CLAUSE_W-1:0] v,
                            input logic [VS_W-1:0] vs, input logic [LS_W-1:0] ls);
    @(negedge clk);
    mod_en = 1'b1; mod_row = CL_AW'(row); mod_val = v; mod_vs = vs; mod_ls = ls;
    @(negedge clk);
    mod_en = 1'b0;
  endtask

  task automatic engine_done(input int dly, input logic s, input logic u, input logic [WIDTH_LVL-1:0] cl,
                             input logic [WIDTH_LVL-1:0] bl, input logic [WIDTH_BIN_ID-1:0] bb);
    repeat (dly) @(negedge clk);
    done_core_i = 1'b1; sat_i = s; unsat_i = u; cur_lvl_i = cl; bkt_lvl_i = bl; bkt_bin_i = bb;
    t_dcore = cyc;
    @(negedge clk);
    done_core_i = 1'b0; sat_i = 1'b0; unsat_i = 1'b0; cur_lvl_i = '0; bkt_lvl_i = '0; bkt_bin_i = '0;
  endtask

  initial begin
    int log_base, ns0, nd0;
    logic [VS_W-1:0] vs_a, vs_b;
    logic [LS_W-1:0] ls_a, ls_b;

    rst = 1'b1; start_i = 1'b0; bin_id_i = '0; load_lvl_i = '0; base_lvl_i = '0;
    done_core_i = 1'b0; sat_i = 1'b0; unsat_i = 1'b0;
    cur_lvl_i = '0; bkt_lvl_i = '0; bkt_bin_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_done", 256'(done_o), 256'd0);
    check("rst_sat", 256'(sat_o), 256'd0);
    check("rst_unsat", 256'(unsat_o), 256'd0);
    check("rst_strobes", 256'({cmem_rd_o, cmem_wr_o, smem_rd_o, smem_wr_o, start_core_o, base_lvl_en_o}), 256'd0);
    check("rst_carray", 256'({wr_carray_o, rd_carray_o}), 256'd0);
    check("rst_results", 256'({cur_lvl_o, bkt_lvl_o, bkt_bin_o}), 256'd0);

    // Bin 3: load pattern then sat result after 20 engine cycles.
    for (int k = 0; k < N; k++) preload_c(10'd3, k, 16'(k + 1));
    vs_a = {8{19'h12345}}; ls_a = {8{11'h5A3}};
    preload_s(10'd3, vs_a, ls_a);
    log_base = wr_oh_log.size(); ns0 = n_start; nd0 = n_done;
    issue_start(10'd3, 16'd9, 16'd4, 1'b0);
    wait_core();
    check("op1_core_lat", 256'(t_core - t_issue), 256'd12);
    check("op1_load_lvl", 256'(load_lvl_o), 256'd9);
    check("op1_base_lvl", 256'(base_lvl_o), 256'd4);
    check("op1_bin_num", 256'(cur_bin_num_o), 256'd3);
    check("op1_eng_vs", 256'(eng_vs), 256'(vs_a));
    check("op1_eng_ls", 256'(eng_ls), 256'(ls_a));
    engine_done(20, 1'b1, 1'b0, 16'd5, 16'd0, 10'd0);
    wait_done();
    check("op1_done_lat", 256'(t_done - t_dcore), 256'd10);
    @(negedge clk);
    check("op1_sat", 256'(sat_o), 256'd1);
    check("op1_unsat", 256'(unsat_o), 256'd0);
    check("op1_cur_lvl", 256'(cur_lvl_o), 256'd5);
    check("op1_n_start", 256'(n_start - ns0), 256'd1);
    check("op1_n_done", 256'(n_done - nd0), 256'd1);
`ifdef SAT_BIN_LOADER_CYCLE_CNT_EN
    check("op1_run_cycles", 256'(run_cycles_o), 256'd20);
`endif
    check("op1_log_len", 256'(wr_oh_log.size() - log_base), 256'(N));
    for (int k = 0; k < N; k++) begin
      check($sformatf("op1_rd_addr%0d", k), 256'(rd_addr_log[log_base + k]), 256'(24 + k));
      check($sformatf("op1_wr_oh%0d", k), 256'(wr_oh_log[log_base + k]), 256'(1 << k));
      check($sformatf("op1_wr_cl%0d", k), 256'(wr_cl_log[log_base + k]), 256'(k + 1));
      check($sformatf("op1_wr_cyc%0d", k), 256'(wr_cyc_log[log_base + k] - t_issue), 256'(2 + k));
    end

    // Bin 5: unsat with backtrack, engine rewrites row 4 and its state vectors.
    for (int k = 0; k < N; k++) preload_c(10'd5, k, 16'h0500 + 16'(k));
    preload_s(10'd5, {8{19'h70F0F}}, {8{11'h3C3}});
    vs_b = {8{19'h01111}}; ls_b = {8{11'h0AA}};
    issue_start(10'd5, 16'd1, 16'd0, 1'b0);
    wait_core();
    eng_modify(4, 16'hA5A5, vs_b, ls_b);
    engine_done(3, 1'b0, 1'b1, 16'd3, 16'd2, 10'd7);
    wait_done();
    @(negedge clk);
    check("op2_unsat", 256'(unsat_o), 256'd1);
    check("op2_sat", 256'(sat_o), 256'd0);
    check("op2_bkt_lvl", 256'(bkt_lvl_o), 256'd2);
    check("op2_bkt_bin", 256'(bkt_bin_o), 256'd7);
    check("op2_cur_lvl", 256'(cur_lvl_o), 256'd3);
    check("op2_row4", 256'(cmem[{10'd5, 3'd4}]), 256'h0000A5A5);
    check("op2_row2", 256'(cmem[{10'd5, 3'd2}]), 256'h00000502);
    check("op2_smem_vs", 256'(svs[5]), 256'(vs_b));
    check("op2_smem_ls", 256'(sls[5]), 256'(ls_b));

    // Bin 2: start held high through RUN and a stray engine done during LD_C.
    for (int k = 0; k < N; k++) preload_c(10'd2, k, 16'h0200 + 16'(k));
    ns0 = n_start; nd0 = n_done;
    issue_start(10'd2, 16'd6, 16'd1, 1'b1);
    repeat (3) @(negedge clk);
    done_core_i = 1'b1; sat_i = 1'b1; cur_lvl_i = 16'd99;
    @(negedge clk);
    done_core_i = 1'b0; sat_i = 1'b0; cur_lvl_i = '0;
    wait_core();
    check("op3_core_lat", 256'(t_core - t_issue), 256'd12);
    engine_done(5, 1'b0, 1'b0, 16'd8, 16'd0, 10'd0);
    start_i = 1'b0;
    wait_done();
    check("op3_done_lat", 256'(t_done - t_dcore), 256'd10);
    repeat (30) @(negedge clk);
    check("op3_n_start", 256'(n_start - ns0), 256'd1);
    check("op3_n_done", 256'(n_done - nd0), 256'd1);
    check("op3_cur_lvl", 256'(cur_lvl_o), 256'd8);

    // Bin 6: reset during write-back of row 3.
    for (int k = 0; k < N; k++) preload_c(10'd6, k, 16'h1000 + 16'(k));
    preload_s(10'd6, vs_a, ls_a);
    nd0 = n_done;
    issue_start(10'd6, 16'd2, 16'd2, 1'b0);
    wait_core();
    for (int k = 0; k < N; k++) eng_modify(k, 16'hE000 + 16'(k), vs_b, ls_b);
    engine_done(1, 1'b1, 1'b0, 16'd7, 16'd0, 10'd0);
    repeat (3) @(negedge clk);
    check("op4_wb_row3_wr", 256'(cmem_wr_o), 256'd1);
    check("op4_wb_row3_oh", 256'(rd_carray_o), 256'h08);
    rst = 1'b1;
    @(negedge clk);
    check("op4_rst_strobes", 256'({cmem_rd_o, cmem_wr_o, smem_rd_o, smem_wr_o, start_core_o, done_o}), 256'd0);
    check("op4_rst_carray", 256'({wr_carray_o, rd_carray_o}), 256'd0);
    check("op4_rst_sat", 256'(sat_o), 256'd0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("op4_n_done", 256'(n_done - nd0), 256'd0);
    for (int k = 0; k < N; k++) begin
      check($sformatf("op4_row%0d", k), 256'(cmem[{10'd6, 3'(k)}]),
            (k < 4) ? 256'(16'hE000 + 16'(k)) : 256'(16'h1000 + 16'(k)));
    end
    check("op4_smem_vs", 256'(svs[6]), 256'(vs_a));

    // Bin 1 after reset: done on the very first RUN cycle.
    issue_start(10'd1, 16'd3, 16'd3, 1'b0);
    wait_core();
    check("op5_core_lat", 256'(t_core - t_issue), 256'd12);
    engine_done(1, 1'b1, 1'b1, 16'd4, 16'd1, 10'd9);
    wait_done();
    check("op5_done_lat", 256'(t_done - t_dcore), 256'd10);
    @(negedge clk);
    check("op5_sat_unsat", 256'({sat_o, unsat_o}), 256'd3);
    check("op5_bkt_bin", 256'(bkt_bin_o), 256'd9);
`ifdef SAT_BIN_LOADER_CYCLE_CNT_EN
    check("op5_run_cycles", 256'(run_cycles_o), 256'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sat_bin_loader.md
Name: sat_bin_loader

Overview:
- Initiator side of the sat_engine core interface: swaps one bin in and out of the engine.
- Fetches the bin's clauses and var/lvl state vectors from bin memory and writes them into the engine, then pulses start.
- Waits for the engine's done, captures sat/unsat/backtrack results, and writes the updated clauses and states back to bin memory.
- Sits between the top-level bin scheduler and sat_engine.

Parameters:
NUM_CLAUSES, 8, clause rows per bin
NUM_VARS, 8, vars per bin (clause row = NUM_VARS*2 bits)
NUM_LVLS, 8, lvl-state entries per bin
WIDTH_BIN_ID, 10, bin id width
WIDTH_LVL, 16, level width
WIDTH_VAR_STATES, 19, bits per var state
WIDTH_LVL_STATES, 11, bits per lvl state

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_i  in  1  scheduler request; sampled only in IDLE
bin_id_i  in  WIDTH_BIN_ID  bin to process
load_lvl_i  in  WIDTH_LVL  level passed to the engine
base_lvl_i  in  WIDTH_LVL  base level passed to the engine
done_o  out  1  one-cycle completion pulse
sat_o / unsat_o  out  1 each  captured engine result
cur_lvl_o / bkt_lvl_o  out  WIDTH_LVL each  captured engine levels
bkt_bin_o  out  WIDTH_BIN_ID  captured backtrack bin
cmem_rd_o / cmem_wr_o  out  1 each  clause memory strobes
cmem_addr_o  out  WIDTH_BIN_ID+CL_AW  clause address = {bin_id, row}
cmem_wdata_o  out  NUM_VARS*2  clause write data
cmem_rdata_i  in  NUM_VARS*2  clause read data, valid 1 cycle after cmem_rd_o
smem_rd_o / smem_wr_o  out  1 each  state memory strobes
smem_addr_o  out  WIDTH_BIN_ID  state address = bin_id
smem_vs_wdata_o / smem_vs_rdata_i  out/in  WIDTH_VAR_STATES*NUM_VARS  var states; read data has 1-cycle latency
smem_ls_wdata_o / smem_ls_rdata_i  out/in  WIDTH_LVL_STATES*NUM_LVLS  lvl states; read data has 1-cycle latency
start_core_o, cur_bin_num_o, load_lvl_o  out  1/WIDTH_LVL/WIDTH_LVL  engine control
done_core_i, sat_i, unsat_i, cur_lvl_i, bkt_lvl_i, bkt_bin_i  in  engine results
wr_carray_o, rd_carray_o  out  NUM_CLAUSES  one-hot row strobes
clause_o / clause_i  out/in  NUM_VARS*2  clause to engine / from engine (combinational read)
wr_var_states_o, vars_states_o, vars_states_i  engine var-state port
wr_lvl_states_o, lvl_states_o, lvl_states_i  engine lvl-state port
base_lvl_en_o, base_lvl_o  out  1/WIDTH_LVL  engine base level

Behaviour:
- Reset: state IDLE; all strobes, done_o, sat_o, unsat_o = 0; captured result registers = 0.
- IDLE: start_i=1 captures bin_id_i, load_lvl_i and base_lvl_i, then goes to LD_C with row=0.
- LD_C: two-stage pipeline.
  - Cycle k (k<NUM_CLAUSES): cmem_rd_o=1 with addr row k.
  - Cycle k+1: wr_carray_o=1<<k and clause_o=cmem_rdata_i.
  - Lasts NUM_CLAUSES+1 cycles, then LD_S.
- LD_S: smem_rd_o=1 for 1 cycle. Next cycle: wr_var_states_o and wr_lvl_states_o all ones, vectors driven from smem read data, base_lvl_en_o=1. Then START.
- START: start_core_o=1 for exactly 1 cycle. load_lvl_o and cur_bin_num_o stay held for the whole operation.
- RUN: waits for done_core_i. On done, captures sat_i, unsat_i, cur_lvl_i, bkt_lvl_i and bkt_bin_i, then goes to WB_C. done_core_i is ignored outside RUN.
- WB_C: for row k=0..NUM_CLAUSES-1, one per cycle: rd_carray_o=1<<k, cmem_wr_o=1, cmem_wdata_o=clause_i. Learnt clauses are written back too.
- WB_S: smem_wr_o=1 for 1 cycle with vars_states_i and lvl_states_i.
- DONE: done_o=1 for 1 cycle, then IDLE. Results stay held until the next start.
- Total latency excluding RUN: 2*NUM_CLAUSES+6 cycles.
- start_i outside IDLE is ignored.
- sat and unsat both high: both are captured as-is, no arbitration.
- rst mid-operation: IDLE on the next cycle, no further memory writes; partial write-back is not repaired.
- Row counter width CL_AW = clog2(NUM_CLAUSES). The counter compare is exact at NUM_CLAUSES-1, no wrap.

Optional Feature:
- Macro: SAT_BIN_LOADER_CYCLE_CNT_EN.
- Defined: adds output run_cycles_o[31:0]. The counter clears on START and increments each RUN cycle, saturating at all-ones. It holds through DONE.
- Undefined: no port and no counter logic.

Decomposition:
- Package sat_bin_pkg: FSM state enum (IDLE, LD_C, LD_S, START, RUN, WB_C, WB_S, DONE), CL_AW, clause/state vector width constants.
- One sub-module, bin_row_seq: row counter plus one-hot decoder, with start/last/busy outputs. It is reused by LD_C and WB_C.

Test Plan:
- Load only: bin_id=3, clause memory rows 0..7 = 16'h0001..16'h0008 -> wr_carray_o=8'h01..8'h80 on consecutive cycles carrying those values; cmem_addr_o=30..37 at bin id<<3.
- Full run, engine model returns done after 20 cycles with sat=1, cur_lvl=5 -> start_core_o pulses once; sat_o=1, cur_lvl_o=5 held after done_o.
- Unsat, engine returns bkt_lvl=2, bkt_bin=7, engine clause row 4 changed to 16'hA5A5 -> bkt outputs 2/7; memory row 4 = 16'hA5A5 after write-back.
- start_i held high during RUN and a spurious done_core_i in LD_C -> no restart and no early exit; exactly one done_o.
- rst asserted in WB_C at row 3 -> next cycle all strobes 0 and state IDLE; rows 4..7 not written.
- With SAT_BIN_LOADER_CYCLE_CNT_EN and engine done 20 cycles after start -> run_cycles_o=20.
